// File: rtl/pipe_stage_ctrl.sv
// Stage sequencer: per-stage load enables, valid bits and retire accounting,
// either as a single walking token (MODE 0) or a stallable/flushable pipeline (MODE 1).
module pipe_stage_ctrl #(
   parameter int STAGES = 5,
   parameter int MODE   = 0,
   parameter int CNTW   = 32,
   parameter int SW     = $clog2(STAGES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              halt,
   input  logic [STAGES-1:0] busy,
   input  logic              flush,
   input  logic [SW-1:0]     flush_stage,
   output logic [STAGES-1:0] stage_en,
   output logic [STAGES-1:0] stage_valid,
   output logic              retire,
   output logic [CNTW-1:0]   retire_cnt,
   output logic [SW-1:0]     occupancy
);

   localparam int LAST = STAGES - 1;

   logic [STAGES-1:0] valid_p0;
   logic [CNTW-1:0]   cnt_p0;
   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] kill;
   logic [STAGES-1:0] in_en;
   logic [STAGES-1:0] valid_next;
   logic              accept;
   logic              retire_int;

   function automatic logic [SW-1:0] popcount(input logic [STAGES-1:0] v);
      logic [SW-1:0] n;
      n = '0;
      for (int i = 0; i < STAGES; i++) n = n + SW'(v[i]);
      return n;
   endfunction

   // Stalls ripple from writeback toward stage 0 within the same cycle.
   always_comb begin
      logic [STAGES-1:0] a;
      a       = '0;
      a[LAST] = valid_p0[LAST] & ~busy[LAST];
      for (int i = LAST - 1; i >= 0; i--)
         a[i] = valid_p0[i] & ~busy[i] & (~valid_p0[i+1] | a[i+1]);
      adv = a;
   end

   always_comb begin
      kill = '0;
      for (int i = 0; i < STAGES; i++)
         kill[i] = flush & (int'(flush_stage) > i);
   end

   generate
      if (MODE == 0) begin : g_token
         logic empty;
         assign empty  = ~|valid_p0;
         assign accept = ~halt & ~flush & (empty | adv[LAST]);
      end else begin : g_pipe
         assign accept = ~halt & ~flush & (~valid_p0[0] | adv[0]);
      end
   endgenerate

   assign in_en      = {adv[LAST-1:0] & ~kill[LAST-1:0], accept};
   assign valid_next = (valid_p0 & ~adv & ~kill) | in_en;
   assign retire_int = adv[LAST] & ~kill[LAST];

   // Registered stage state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_p0 <= '0;
         cnt_p0   <= '0;
      end else begin
         valid_p0 <= valid_next;
         if (retire_int) cnt_p0 <= cnt_p0 + CNTW'(1);
      end
   end

   // Combinational outputs are held low while reset is asserted.
   assign stage_en    = rst ? in_en : '0;
   assign retire      = rst & retire_int;
   assign occupancy   = rst ? popcount(valid_p0) : '0;
   assign stage_valid = valid_p0;
   assign retire_cnt  = cnt_p0;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Bench for pipe_stage_ctrl: one token-mode and one pipelined instance checked
// against directed tables and a slot-level behavioural model.
module tb_pipe_stage_ctrl;

   localparam int ST = 5;
   localparam int SW = 3;
   localparam int CW = 8;
   localparam logic [ST-1:0] ONE = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          halt_a, flush_a, halt_b, flush_b;
   logic [ST-1:0] busy_a, busy_b;
   logic [SW-1:0] fs_a, fs_b;
   logic [ST-1:0] en_a, val_a, en_b, val_b;
   logic          ret_a, ret_b;
   logic [CW-1:0] cnt_a, cnt_b;
   logic [SW-1:0] occ_a, occ_b;

   pipe_stage_ctrl #(.STAGES(ST), .MODE(0), .CNTW(CW), .SW(SW)) dut_a (
      .clk(clk), .rst(rst), .halt(halt_a), .busy(busy_a), .flush(flush_a),
      .flush_stage(fs_a), .stage_en(en_a), .stage_valid(val_a), .retire(ret_a),
      .retire_cnt(cnt_a), .occupancy(occ_a));

   pipe_stage_ctrl #(.STAGES(ST), .MODE(1), .CNTW(CW), .SW(SW)) dut_b (
      .clk(clk), .rst(rst), .halt(halt_b), .busy(busy_b), .flush(flush_b),
      .flush_stage(fs_b), .stage_en(en_b), .stage_valid(val_b), .retire(ret_b),
      .retire_cnt(cnt_b), .occupancy(occ_b));

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [ST-1:0] en_a;
      logic [ST-1:0] val_a;
      logic          ret_a;
      int            occ_b;
      logic          ret_b;
   } vec_t;
   vec_t tbl [21];

   // model state: token position for MODE 0, slot occupancy for MODE 1
   int            pos_m, pos_nx;
   logic [ST-1:0] occ_m, occ_nx;
   logic [CW-1:0] cnt_ma, cnt_ma_nx, cnt_mb, cnt_mb_nx, acc_mb, acc_mb_nx;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic reset_models();
      pos_m  = -1;
      occ_m  = '0;
      cnt_ma = '0;
      cnt_mb = '0;
      acc_mb = '0;
   endtask

   task automatic set_idle();
      halt_a = 1'b0; flush_a = 1'b0; busy_a = '0; fs_a = '0;
      halt_b = 1'b0; flush_b = 1'b0; busy_b = '0; fs_b = '0;
   endtask

   task automatic model_check();
      logic [ST-1:0] en_e, val_e;
      logic          ret_e, mv, kd, acc;
      if (!rst) begin
         cmp("rst_a_en", 32'(en_a), 0);   cmp("rst_a_valid", 32'(val_a), 0);
         cmp("rst_a_retire", 32'(ret_a), 0); cmp("rst_a_cnt", 32'(cnt_a), 0);
         cmp("rst_a_occ", 32'(occ_a), 0);
         cmp("rst_b_en", 32'(en_b), 0);   cmp("rst_b_valid", 32'(val_b), 0);
         cmp("rst_b_retire", 32'(ret_b), 0); cmp("rst_b_cnt", 32'(cnt_b), 0);
         cmp("rst_b_occ", 32'(occ_b), 0);
         return;
      end
      // single token
      en_e  = '0;
      ret_e = 1'b0;
      mv    = 1'b0;
      if (pos_m >= 0) mv = !busy_a[pos_m];
      kd    = (pos_m >= 0) && flush_a && (pos_m < int'(fs_a));
      acc   = !halt_a && !flush_a && ((pos_m < 0) || (pos_m == ST - 1 && mv));
      if (mv && !kd) begin
         if (pos_m == ST - 1) ret_e = 1'b1;
         else en_e[pos_m+1] = 1'b1;
      end
      if (acc) en_e[0] = 1'b1;
      val_e = (pos_m >= 0) ? (ONE << pos_m) : '0;
      cmp("a_en", 32'(en_a), 32'(en_e));
      cmp("a_valid", 32'(val_a), 32'(val_e));
      cmp("a_retire", 32'(ret_a), 32'(ret_e));
      cmp("a_cnt", 32'(cnt_a), 32'(cnt_ma));
      cmp("a_occ", 32'(occ_a), (pos_m >= 0) ? 1 : 0);
      pos_nx = pos_m;
      if (pos_m >= 0) begin
         if (kd) pos_nx = -1;
         else if (mv) pos_nx = (pos_m == ST - 1) ? -1 : pos_m + 1;
      end
      if (acc) pos_nx = 0;
      cnt_ma_nx = cnt_ma + CW'(ret_e);

      // pipelined: oldest slot claims its destination first
      en_e   = '0;
      ret_e  = 1'b0;
      occ_nx = '0;
      for (int i = ST - 1; i >= 0; i--) begin
         if (occ_m[i] && !(flush_b && i < int'(fs_b))) begin
            if (busy_b[i]) occ_nx[i] = 1'b1;
            else if (i == ST - 1) ret_e = 1'b1;
            else if (!occ_nx[i+1]) begin
               occ_nx[i+1] = 1'b1;
               en_e[i+1]   = 1'b1;
            end else occ_nx[i] = 1'b1;
         end
      end
      acc = !halt_b && !flush_b && !occ_nx[0];
      if (acc) begin
         occ_nx[0] = 1'b1;
         en_e[0]   = 1'b1;
      end
      cmp("b_en", 32'(en_b), 32'(en_e));
      cmp("b_valid", 32'(val_b), 32'(occ_m));
      cmp("b_retire", 32'(ret_b), 32'(ret_e));
      cmp("b_cnt", 32'(cnt_b), 32'(cnt_mb));
      cmp("b_occ", 32'(occ_b), $countones(occ_m));
      cnt_mb_nx = cnt_mb + CW'(ret_e);
      acc_mb_nx = acc_mb + CW'(acc);
   endtask

   task automatic sample();
      #1;
      model_check();
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         pos_m  = pos_nx;
         occ_m  = occ_nx;
         cnt_ma = cnt_ma_nx;
         cnt_mb = cnt_mb_nx;
         acc_mb = acc_mb_nx;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      reset_models();
      set_idle();
      @(negedge clk);
      sample();
      @(negedge clk);
      rst = 1'b1;
      cyc = 0;
   endtask

   initial begin
      for (int c = 0; c < 21; c++) begin
         tbl[c].en_a  = ONE << (c % ST);
         tbl[c].val_a = (c == 0) ? '0 : (ONE << ((c - 1) % ST));
         tbl[c].ret_a = (c > 0) && (c % ST == 0);
         tbl[c].occ_b = (c < ST) ? c : ST;
         tbl[c].ret_b = (c >= ST);
      end
      rst = 1'b0;
      set_idle();
      reset_models();
      do_reset();

      // free-running walk / ramp
      for (int c = 0; c < 21; c++) begin
         sample();
         cmp("tbl_a_en", 32'(en_a), 32'(tbl[c].en_a));
         cmp("tbl_a_valid", 32'(val_a), 32'(tbl[c].val_a));
         cmp("tbl_a_retire", 32'(ret_a), 32'(tbl[c].ret_a));
         cmp("tbl_b_occ", 32'(occ_b), tbl[c].occ_b);
         cmp("tbl_b_retire", 32'(ret_b), 32'(tbl[c].ret_b));
         if (c == 11) cmp("b_cnt_after10", 32'(cnt_b), 6);
         tick();
      end
      sample();
      cmp("a_cnt_after20", 32'(cnt_a), 4);
      cmp("b_cnt_after20", 32'(cnt_b), 16);

      // token held in stage 3 for three cycles
      do_reset();
      for (int c = 0; c < 10; c++) begin
         busy_a = (c >= 4 && c <= 6) ? 5'b01000 : 5'b00000;
         sample();
         cmp("hold_retire", 32'(ret_a), 32'(c == 8));
         if (c >= 4 && c <= 6) cmp("hold_en", 32'(en_a), 0);
         if (c == 7) cmp("hold_release_en", 32'(en_a), 32'(5'b10000));
         tick();
      end
      busy_a = '0;

      // stage-2 stall on a full pipe, then drain and reconcile counts
      for (int c = 0; c < 2; c++) begin
         busy_b = 5'b00100;
         sample();
         cmp("stall_en_low", 32'(en_b[2:0]), 0);
         tick();
      end
      busy_b = '0;
      for (int c = 0; c < 3; c++) begin sample(); tick(); end
      halt_b = 1'b1;
      for (int c = 0; c < 8; c++) begin sample(); tick(); end
      sample();
      cmp("drain_occ", 32'(occ_b), 0);
      cmp("drain_count", 32'(cnt_b), 32'(acc_mb));
      tick();
      halt_b = 1'b0;

      // flush below stage 2 on a full pipe
      for (int c = 0; c < 6; c++) begin sample(); tick(); end
      flush_b = 1'b1;
      fs_b    = 3'd2;
      sample();
      cmp("flush_full", 32'(occ_b), 5);
      cmp("flush_en0", 32'(en_b[0]), 0);
      cmp("flush_en3", 32'(en_b[3]), 1);
      tick();
      flush_b = 1'b0;
      fs_b    = '0;
      sample();
      cmp("flush_v01", 32'(val_b[1:0]), 0);
      cmp("flush_v3", 32'(val_b[3]), 1);
      cmp("refill_en0", 32'(en_b[0]), 1);
      tick();

      // asynchronous reset mid-stream
      do_reset();
      for (int c = 0; c < 12; c++) begin sample(); tick(); end
      sample();
      cmp("pre_reset_cnt", 32'(cnt_b), 7);
      #2;
      rst = 1'b0;
      reset_models();
      #1;
      cmp("async_b_en", 32'(en_b), 0);
      cmp("async_b_valid", 32'(val_b), 0);
      cmp("async_b_retire", 32'(ret_b), 0);
      cmp("async_b_cnt", 32'(cnt_b), 0);
      cmp("async_b_occ", 32'(occ_b), 0);
      cmp("async_a_valid", 32'(val_a), 0);
      @(negedge clk);
      sample();
      rst = 1'b1;
      cyc = 0;
      sample();
      cmp("post_reset_en0_b", 32'(en_b[0]), 1);
      cmp("post_reset_en0_a", 32'(en_a[0]), 1);
      tick();

      // randomized traffic on both instances
      for (int k = 0; k < 400; k++) begin
         halt_a  = ($urandom_range(0, 7) == 0);
         halt_b  = ($urandom_range(0, 7) == 0);
         flush_a = ($urandom_range(0, 9) == 0);
         flush_b = ($urandom_range(0, 9) == 0);
         fs_a    = SW'($urandom_range(0, 7));
         fs_b    = SW'($urandom_range(0, 7));
         for (int i = 0; i < ST; i++) begin
            busy_a[i] = ($urandom_range(0, 5) == 0);
            busy_b[i] = ($urandom_range(0, 5) == 0);
         end
         sample();
         tick();
      end
      set_idle();
      sample();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
